// File: rtl/game_pkg.sv
// game_pkg: game phase encoding and player HP state enum shared across game logic
package game_pkg;
    typedef enum logic [1:0] {
        MENU       = 2'd0,
        GAME       = 2'd1,
        END_SCREEN = 2'd2
    } game_state_t;
    typedef enum logic [1:0] {
        HP_IDLE,
        HP_ALIVE,
        HP_INVULN,
        HP_DEAD
    } hp_state_t;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: frame-based down-counter with load, clear and expiry on the last tick
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         expired
);
    assign expired = tick && count == W'(1);
    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - W'(1);
    end
endmodule

// File: rtl/player_hp_ctrl.sv
// player_hp_ctrl: player health FSM with saturating damage/heal and post-hit invulnerability
module player_hp_ctrl
    import game_pkg::*;
#(
    parameter int MAX_HP        = 8,
    parameter int INVULN_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic       frame_tick,
    input  logic       dmg_hit,
    input  logic [2:0] dmg_amount,
    input  logic       heal_req,
    output logic [3:0] current_health,
    output logic       player_alive,
    output logic       invuln,
    output logic       blink
);
    localparam logic [3:0] FULL = 4'(MAX_HP);
    hp_state_t st, st_n;
    logic [1:0] prev_gs;
    logic [3:0] hp_n, dmg_res, heal_res;
    logic [7:0] count;
    logic in_game, round_start, hit, load, clear, expired, unused_count;
    assign in_game     = game_state == GAME;
    assign round_start = in_game && prev_gs != GAME;
    assign hit         = dmg_hit && dmg_amount != 3'd0;
    assign dmg_res     = current_health > {1'b0, dmg_amount} ? current_health - {1'b0, dmg_amount} : 4'd0;
    assign heal_res    = current_health < FULL ? current_health + 4'd1 : current_health;
    assign blink        = invuln && count[2];
    assign unused_count = ^{count[7:3], count[1:0]};
    frame_timer #(.W(8)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .load     (load),
        .load_val (8'(INVULN_FRAMES)),
        .tick     (frame_tick && st == HP_INVULN),
        .count    (count),
        .expired  (expired)
    );
    // Leaving GAME beats round start, which beats any damage/heal event in the same cycle.
    always_comb begin
        st_n  = st;
        hp_n  = current_health;
        load  = 1'b0;
        clear = 1'b0;
        if (!in_game) begin
            st_n  = HP_IDLE;
            clear = 1'b1;
        end else if (round_start) begin
            st_n  = HP_ALIVE;
            hp_n  = FULL;
            clear = 1'b1;
        end else if (st == HP_ALIVE) begin
            if (hit) begin
                hp_n = dmg_res;
                st_n = dmg_res != 4'd0 ? HP_INVULN : HP_DEAD;
                load = dmg_res != 4'd0;
            end else if (heal_req) begin
                hp_n = heal_res;
            end
        end else if (st == HP_INVULN) begin
            hp_n = heal_req ? heal_res : current_health;
            st_n = expired ? HP_ALIVE : HP_INVULN;
        end else if (st == HP_DEAD) begin
            hp_n = 4'd0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= HP_IDLE;
            current_health <= FULL;
            prev_gs        <= MENU;
            player_alive   <= 1'b0;
            invuln         <= 1'b0;
        end else begin
            st             <= st_n;
            current_health <= hp_n;
            prev_gs        <= game_state;
            player_alive   <= st_n == HP_ALIVE || st_n == HP_INVULN;
            invuln         <= st_n == HP_INVULN;
        end
    end
endmodule

// File: tb/tb_player_hp_ctrl.sv
// tb_player_hp_ctrl: directed scenarios plus randomized traffic against a behavioural HP model
module tb_player_hp_ctrl;
    localparam int MAXHP = 8;
    localparam int IFR   = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] game_state = 2'd0;
    logic       frame_tick = 1'b0;
    logic       dmg_hit = 1'b0;
    logic [2:0] dmg_amount = 3'd0;
    logic       heal_req = 1'b0;
    logic [3:0] current_health;
    logic       player_alive, invuln, blink;
    int n_chk = 0;
    int n_pass = 0;
    int m_hp = MAXHP;
    int m_inv = 0;
    bit m_play = 0;
    bit m_dead = 0;
    int m_prev = 0;

    player_hp_ctrl #(.MAX_HP(MAXHP), .INVULN_FRAMES(IFR)) dut (
        .clk            (clk),
        .rst            (rst),
        .game_state     (game_state),
        .frame_tick     (frame_tick),
        .dmg_hit        (dmg_hit),
        .dmg_amount     (dmg_amount),
        .heal_req       (heal_req),
        .current_health (current_health),
        .player_alive   (player_alive),
        .invuln         (invuln),
        .blink          (blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Health rules stated directly: round flag, dead flag, frames of invulnerability left.
    task automatic model_update();
        if (rst) begin
            m_hp = MAXHP; m_play = 0; m_dead = 0; m_inv = 0; m_prev = 0;
            return;
        end
        if (game_state != 2'd1) begin
            m_play = 0; m_dead = 0; m_inv = 0;
        end else if (m_prev != 1) begin
            m_play = 1; m_dead = 0; m_inv = 0; m_hp = MAXHP;
        end else if (m_play && !m_dead) begin
            if (m_inv > 0) begin
                if (heal_req) m_hp = (m_hp + 1 > MAXHP) ? MAXHP : m_hp + 1;
                if (frame_tick) m_inv = m_inv - 1;
            end else if (dmg_hit && dmg_amount != 0) begin
                m_hp = (m_hp - int'(dmg_amount) < 0) ? 0 : m_hp - int'(dmg_amount);
                if (m_hp == 0) m_dead = 1;
                else m_inv = IFR;
            end else if (heal_req) begin
                m_hp = (m_hp + 1 > MAXHP) ? MAXHP : m_hp + 1;
            end
        end
        m_prev = int'(game_state);
    endtask

    task automatic step(input logic r, input logic [1:0] g, input logic t,
                        input logic h, input logic [2:0] a, input logic hl);
        @(negedge clk);
        rst = r; game_state = g; frame_tick = t; dmg_hit = h; dmg_amount = a; heal_req = hl;
        @(posedge clk);
        model_update();
        #1;
        check("hp", int'(current_health), m_hp);
        check("alive", int'(player_alive), int'(m_play && !m_dead));
        check("invuln", int'(invuln), int'(m_play && m_inv > 0));
        check("blink", int'(blink), int'(m_play && m_inv[2]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 2'd1, 1, 0, 3'd0, 0);
    endtask

    initial begin
        logic [1:0] gs;
        step(1, 2'd0, 0, 0, 3'd0, 0);
        check("reset_hp", int'(current_health), 8);
        check("reset_alive", int'(player_alive), 0);
        step(0, 2'd0, 0, 0, 3'd0, 0);
        step(0, 2'd1, 0, 0, 3'd0, 0);
        check("start_hp", int'(current_health), 8);
        check("start_alive", int'(player_alive), 1);
        step(0, 2'd1, 0, 1, 3'd3, 0);
        check("hit3_hp", int'(current_health), 5);
        check("hit3_inv", int'(invuln), 1);
        for (int i = 0; i < 9; i++) step(0, 2'd1, 0, 0, 3'd0, 0);
        step(0, 2'd1, 0, 1, 3'd3, 0);
        check("inv_ignore_hp", int'(current_health), 5);
        ticks(3);
        check("inv_before_4th", int'(invuln), 1);
        ticks(1);
        check("inv_drop", int'(invuln), 0);
        step(0, 2'd1, 0, 1, 3'd2, 0);
        check("hit2_hp", int'(current_health), 3);
        ticks(IFR);
        for (int i = 0; i < 6; i++) step(0, 2'd1, 0, 0, 3'd0, 1);
        check("heal_sat", int'(current_health), 8);
        step(0, 2'd1, 0, 1, 3'd4, 0);
        ticks(IFR);
        step(0, 2'd1, 0, 1, 3'd1, 1);
        check("hit_beats_heal", int'(current_health), 3);
        ticks(IFR);
        step(0, 2'd1, 0, 1, 3'd1, 0);
        ticks(IFR);
        check("hp2", int'(current_health), 2);
        step(0, 2'd1, 0, 1, 3'd7, 0);
        check("dead_hp", int'(current_health), 0);
        check("dead_alive", int'(player_alive), 0);
        step(0, 2'd1, 0, 0, 3'd0, 1);
        check("dead_heal", int'(current_health), 0);
        step(0, 2'd2, 0, 0, 3'd0, 0);
        step(0, 2'd1, 0, 1, 3'd5, 1);
        check("restart_hp", int'(current_health), 8);
        check("restart_alive", int'(player_alive), 1);
        step(0, 2'd1, 0, 1, 3'd1, 0);
        step(1, 2'd1, 1, 1, 3'd2, 1);
        check("rst_inv_hp", int'(current_health), 8);
        check("rst_inv_inv", int'(invuln), 0);
        gs = 2'd1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) gs = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) gs = 2'd1;
            step($urandom_range(0, 299) == 0, gs, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 6) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/player_hp_ctrl.md
PLAYER_HP_CTRL -- requirements
Module: player_hp_ctrl

Interface
REQ-001 Parameter MAX_HP, default 8, full health value; legal range 1..15.
REQ-002 Parameter INVULN_FRAMES, default 60, post-hit invulnerability length in frames; legal range 1..255.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 game_state  input  2  game phase from the game FSM: 0 MENU, 1 GAME, 2 END_SCREEN.
REQ-006 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 dmg_hit  input  1  one-cycle damage event from collision logic.
REQ-008 dmg_amount  input  3  damage applied with dmg_hit; 0 = ignore event.
REQ-009 heal_req  input  1  one-cycle heal pickup event, +1 HP.
REQ-010 current_health  output  4  registered player HP, consumed by the game FSM and the HUD.
REQ-011 player_alive  output  1  high when HP > 0 and a round is running.
REQ-012 invuln  output  1  high while in INVULN.
REQ-013 blink  output  1  sprite blink enable: invuln AND bit 2 of the remaining-frame counter.

Function
REQ-014 States: IDLE, ALIVE, INVULN, DEAD; all outputs registered.
REQ-015 Round start: previous game_state is registered each cycle; game_state==GAME with previous !=GAME -> next cycle current_health=MAX_HP, state ALIVE, counter cleared. Covers MENU->GAME and END_SCREEN->GAME.
REQ-016 game_state !=GAME, any state -> IDLE next cycle; current_health holds its last value; invuln=0, player_alive=0.
REQ-017 ALIVE, dmg_hit=1, dmg_amount>0 -> current_health = max(current_health - dmg_amount, 0) on the next cycle; use saturating subtraction, no 4-bit wrap.
REQ-018 Damage result >0 -> INVULN, counter loaded with INVULN_FRAMES; result ==0 -> DEAD.
REQ-019 INVULN: dmg_hit ignored; counter decrements on each frame_tick; frame_tick with counter==1 -> ALIVE next cycle; exactly INVULN_FRAMES ticks spent in INVULN.
REQ-020 heal_req in ALIVE or INVULN -> current_health+1, saturating at MAX_HP; does not alter state or counter.
REQ-021 ALIVE, dmg_hit and heal_req in the same cycle -> damage applied, heal discarded.
REQ-022 DEAD: current_health=0, all events ignored; exit only through REQ-015 after leaving and re-entering GAME.
REQ-023 Round start in the same cycle as dmg_hit/heal_req -> round start wins; the events are dropped.
REQ-024 Latency: one cycle from event sample to updated current_health/state outputs.

Reset
REQ-025 On rst: state IDLE, current_health=MAX_HP, counter=0, previous game_state=MENU, player_alive=0, invuln=0, blink=0.
REQ-026 rst during INVULN or DEAD overrides all inputs in that cycle; no event is applied.

Structure
REQ-027 The game_state encoding (MENU/GAME/END_SCREEN) belongs in shared package game_pkg, which the game FSM also uses.
REQ-028 The HP state enum (hp_state_t) also belongs in game_pkg.
REQ-029 The frame-based down-counter is one sub-module, frame_timer: load, frame_tick decrement, expiry flag, remaining-count output.

Verification
REQ-030 MENU->GAME with MAX_HP=8 -> current_health=8 and player_alive=1 one cycle later.
REQ-031 ALIVE HP=8, dmg_hit with amount 3 -> HP=5 next cycle, invuln=1; second hit 10 cycles later -> HP stays 5.
REQ-032 INVULN_FRAMES=4 -> invuln drops one cycle after the 4th frame_tick; hit with amount 2 then -> HP=3.
REQ-033 HP=2, dmg_amount=7 -> HP=0 with no wrap, DEAD, player_alive=0; later heal_req -> HP stays 0.
REQ-034 HP=8 plus heal_req -> HP 8; HP=4 with simultaneous dmg 1 and heal -> HP=3.
REQ-035 DEAD -> END_SCREEN -> GAME -> HP=8, ALIVE; rst asserted mid-INVULN -> HP=8, invuln=0 next cycle.
